// File: rtl/inst_bus_ctrl_pkg.sv
// Shared defines for the instruction bus controller:
// bus widths, FSM state encodings and a small address helper.
package inst_bus_ctrl_pkg;

    localparam int AddrBus = 32;
    localparam int DataBus = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_CANCEL = 3'd4
    } ibc_state_t;

    localparam logic [DataBus-1:0] ZeroWord = '0;

    function automatic logic addr_misaligned(input logic [AddrBus-1:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_bus_ctrl.sv
// Instruction fetch bus controller: one outstanding read,
// request never withdrawn, flushed fetches drained before reuse.
module inst_bus_ctrl
    import inst_bus_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_en,
    input  logic [AddrBus-1:0] pc,
    input  logic               stall,
    input  logic               flush,
    output logic [DataBus-1:0] inst,
    output logic               inst_valid,
    output logic               inst_adel,
    output logic               stallreq,
    output logic               bus_req,
    output logic [AddrBus-1:0] bus_addr,
    input  logic               bus_addr_ok,
    input  logic               bus_data_ok,
    input  logic [DataBus-1:0] bus_rdata
);

    ibc_state_t         r_state;
    ibc_state_t         w_state_nxt;
    logic [DataBus-1:0] r_inst;
    logic [DataBus-1:0] w_inst_nxt;
    logic               r_adel;
    logic               w_adel_nxt;
    logic [AddrBus-1:0] r_req_addr;
    logic [AddrBus-1:0] w_req_addr_nxt;
    logic               r_cancel;
    logic               w_cancel_nxt;
    logic               w_bus_req;
    logic [AddrBus-1:0] w_bus_addr;
    logic               w_stallreq;
    logic               w_fetch;

    assign w_fetch = inst_en & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_inst     <= ZeroWord;
            r_adel     <= 1'b0;
            r_req_addr <= '0;
            r_cancel   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inst     <= w_inst_nxt;
            r_adel     <= w_adel_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_cancel   <= w_cancel_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_inst_nxt     = r_inst;
        w_adel_nxt     = r_adel;
        w_req_addr_nxt = r_req_addr;
        w_cancel_nxt   = r_cancel;
        w_bus_req      = 1'b0;
        w_bus_addr     = r_req_addr;
        w_stallreq     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fetch) begin
                    w_stallreq = 1'b1;
                    if (addr_misaligned(pc)) begin
                        w_state_nxt = S_DONE;
                        w_inst_nxt  = ZeroWord;
                        w_adel_nxt  = 1'b1;
                    end else begin
                        w_bus_req      = 1'b1;
                        w_bus_addr     = pc;
                        w_req_addr_nxt = pc;
                        w_cancel_nxt   = 1'b0;
                        w_state_nxt    = bus_addr_ok ? S_WAIT : S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A flush here cannot retract the request; remember it instead.
                w_bus_req  = 1'b1;
                w_stallreq = 1'b1;
                if (bus_addr_ok) begin
                    w_state_nxt  = (flush | r_cancel) ? S_CANCEL : S_WAIT;
                    w_cancel_nxt = 1'b0;
                end else begin
                    w_cancel_nxt = r_cancel | flush;
                end
            end
            S_WAIT: begin
                w_stallreq = 1'b1;
                if (bus_data_ok) begin
                    if (flush) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_inst_nxt  = bus_rdata;
                        w_adel_nxt  = 1'b0;
                        w_state_nxt = S_DONE;
                    end
                end else if (flush) begin
                    w_state_nxt = S_CANCEL;
                end
            end
            S_CANCEL: begin
                w_stallreq = 1'b1;
                if (bus_data_ok) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (flush | ~stall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign inst       = r_inst;
    assign inst_adel  = r_adel;
    assign inst_valid = (r_state == S_DONE);
    assign bus_req    = w_bus_req & ~rst;
    assign stallreq   = w_stallreq & ~rst;
    assign bus_addr   = rst ? '0 : w_bus_addr;

endmodule

// File: tb/tb_inst_bus_ctrl.sv
// Randomised scoreboard bench for inst_bus_ctrl with a
// transaction-phase reference model and a latency-varying bus slave.
module tb_inst_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_adel;
    logic        stallreq;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    inst_bus_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .inst_en    (inst_en),
        .pc         (pc),
        .stall      (stall),
        .flush      (flush),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_adel  (inst_adel),
        .stallreq   (stallreq),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .bus_rdata  (bus_rdata)
    );

    typedef struct packed {
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        sreq;
        logic        valid;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    typedef enum {MF_FREE, MF_ADDR, MF_DATA, MF_OUT} ph_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    bit          running = 1'b0;

    ph_t         m_ph = MF_FREE;
    logic        m_kill = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_inst = '0;
    logic        m_adel = 1'b0;

    bit          b_reqing = 1'b0;
    bit          b_out = 1'b0;
    int          a_wait = 0;
    int          d_wait = 0;

    int          k_amin, k_amax, k_dmin, k_dmax;
    int          p_en, p_fl, p_st, p_mis, p_rst, p_stray;
    bit          force_rst;
    bit          fix_pc;
    logic [31:0] fixed_pc;
    bit          fix_dat;
    logic [31:0] fixed_dat;

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    function automatic int urange(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
        end
    endtask

    // One cycle: drive the PC side, answer as the bus, predict outputs.
    task automatic step();
        exp_t e;
        @(negedge clk);
        rst     = force_rst || (m_ph == MF_ADDR && pct(p_rst));
        inst_en = pct(p_en);
        flush   = pct(p_fl);
        stall   = pct(p_st);
        if (fix_pc) begin
            pc = fixed_pc;
        end else begin
            pc = $urandom() & 32'hFFFF_FFFC;
            if (pct(p_mis)) pc[1:0] = 2'($urandom_range(1, 3));
        end
        #1;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = $urandom();
        if (rst) begin
            b_out    = 1'b0;
            b_reqing = 1'b0;
        end else begin
            if (b_out) begin
                if (d_wait == 0) begin
                    bus_data_ok = 1'b1;
                    if (fix_dat) bus_rdata = fixed_dat;
                    b_out = 1'b0;
                end else begin
                    d_wait--;
                end
            end else if (pct(p_stray)) begin
                bus_data_ok = 1'b1;
            end
            if (bus_req) begin
                if (!b_reqing) begin
                    b_reqing = 1'b1;
                    a_wait   = urange(k_amin, k_amax);
                end
                if (a_wait == 0) begin
                    bus_addr_ok = 1'b1;
                    b_reqing    = 1'b0;
                    b_out       = 1'b1;
                    d_wait      = urange(k_dmin, k_dmax);
                end else begin
                    a_wait--;
                end
            end
        end
        e     = '0;
        e.rst = rst;
        if (rst) begin
            m_ph   = MF_FREE;
            m_kill = 1'b0;
        end else begin
            case (m_ph)
                MF_FREE: if (inst_en && !flush) begin
                    e.sreq = 1'b1;
                    if (pc[1:0] != 2'b00) begin
                        m_ph   = MF_OUT;
                        m_inst = '0;
                        m_adel = 1'b1;
                    end else begin
                        e.req  = 1'b1;
                        e.addr = pc;
                        m_addr = pc;
                        m_kill = 1'b0;
                        m_ph   = bus_addr_ok ? MF_DATA : MF_ADDR;
                    end
                end
                MF_ADDR: begin
                    e.req  = 1'b1;
                    e.addr = m_addr;
                    e.sreq = 1'b1;
                    m_kill = m_kill | flush;
                    if (bus_addr_ok) m_ph = MF_DATA;
                end
                MF_DATA: begin
                    e.sreq = 1'b1;
                    if (bus_data_ok) begin
                        if (!m_kill && !flush) begin
                            m_ph   = MF_OUT;
                            m_inst = bus_rdata;
                            m_adel = 1'b0;
                        end else begin
                            m_ph = MF_FREE;
                        end
                    end else begin
                        m_kill = m_kill | flush;
                    end
                end
                MF_OUT: begin
                    e.valid = 1'b1;
                    e.inst  = m_inst;
                    e.adel  = m_adel;
                    if (flush || !stall) m_ph = MF_FREE;
                end
                default: m_ph = MF_FREE;
            endcase
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic knobs(input int amin, input int amax, input int dmin,
                         input int dmax, input int en, input int fl,
                         input int st, input int mis);
        k_amin = amin; k_amax = amax;
        k_dmin = dmin; k_dmax = dmax;
        p_en = en; p_fl = fl; p_st = st; p_mis = mis;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (running) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got empty queue want entry");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk1("bus_req", bus_req, mon_e.req);
                    chk1("stallreq", stallreq, mon_e.sreq);
                    chk1("inst_valid", inst_valid, mon_e.valid);
                    if (mon_e.req) chk32("bus_addr", bus_addr, mon_e.addr);
                    if (mon_e.valid) begin
                        chk32("inst", inst, mon_e.inst);
                        chk1("inst_adel", inst_adel, mon_e.adel);
                    end
                    if (mon_e.rst) begin
                        chk32("rst_inst", inst, 32'h0);
                        chk1("rst_adel", inst_adel, 1'b0);
                        chk32("rst_bus_addr", bus_addr, 32'h0);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; inst_en = 1'b0; pc = '0; stall = 1'b0; flush = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        p_rst = 0; p_stray = 0; force_rst = 1'b1;
        fix_pc = 1'b1; fixed_pc = 32'hBFC0_0000;
        fix_dat = 1'b1; fixed_dat = 32'h2408_0001;
        knobs(0, 0, 0, 0, 0, 0, 0, 0);
        running = 1'b1;
        run(2);
        force_rst = 1'b0;
        knobs(0, 0, 0, 0, 100, 0, 0, 0);
        run(8);
        knobs(3, 3, 0, 0, 100, 0, 0, 0);
        run(12);
        fixed_pc = 32'hBFC0_0002;
        run(4);
        fixed_pc = 32'hBFC0_0000;
        knobs(0, 0, 0, 0, 100, 0, 100, 0);
        run(8);
        knobs(0, 0, 2, 2, 100, 0, 0, 0);
        run(2);
        knobs(0, 0, 2, 2, 100, 100, 0, 0);
        run(1);
        knobs(0, 0, 2, 2, 100, 0, 0, 0);
        fix_dat = 1'b1; fixed_dat = 32'hDEAD_BEEF;
        run(6);
        fix_pc = 1'b0; fix_dat = 1'b0;
        p_rst = 6; p_stray = 10;
        knobs(0, 3, 0, 3, 70, 10, 40, 10);
        run(4000);
        #2;
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
